// File: rtl/reg_wb_scheduler_if.sv
// Writeback bus between the execute/memory requesters, decode and the register file write port.
// The scheduler is the slave; the requesters, decode and the register file sit on the master side.
interface reg_wb_scheduler_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         Req0_valid;
  logic [D-1:0] Req0_addr;
  logic [W-1:0] Req0_data;
  logic         Req0_ready;
  logic         Req1_valid;
  logic [D-1:0] Req1_addr;
  logic [W-1:0] Req1_data;
  logic         Req1_ready;
  logic         Reserve_en;
  logic [D-1:0] Reserve_addr;
  logic [D-1:0] Read_addr_0;
  logic [D-1:0] Read_addr_1;
  logic         Read_busy_0;
  logic         Read_busy_1;
  logic         Reg_write_en;
  logic [D-1:0] Reg_write_address;
  logic [W-1:0] Reg_write_data;

  modport slave (
    input  Req0_valid, Req0_addr, Req0_data,
    output Req0_ready,
    input  Req1_valid, Req1_addr, Req1_data,
    output Req1_ready,
    input  Reserve_en, Reserve_addr, Read_addr_0, Read_addr_1,
    output Read_busy_0, Read_busy_1,
    output Reg_write_en, Reg_write_address, Reg_write_data
  );

  modport master (
    output Req0_valid, Req0_addr, Req0_data,
    input  Req0_ready,
    output Req1_valid, Req1_addr, Req1_data,
    input  Req1_ready,
    output Reserve_en, Reserve_addr, Read_addr_0, Read_addr_1,
    input  Read_busy_0, Read_busy_1,
    input  Reg_write_en, Reg_write_address, Reg_write_data
  );
endinterface

// File: rtl/reg_wb_scheduler.sv
// Round-robin arbiter for the single register file write port (ALU vs load return),
// a one-entry registered issue stage, and a per-register pending-write scoreboard.
module reg_wb_scheduler #(
  parameter int W = 8,
  parameter int D = 3
) (
  input logic               CLK,
  input logic               Reset,
  reg_wb_scheduler_if.slave bus
);
  localparam int unsigned NREG = 2 ** D;

  typedef enum logic {
    PRIO_ALU  = 1'b0,
    PRIO_LOAD = 1'b1
  } prio_t;

  prio_t            r_prio;
  logic             r_wen;
  logic [D-1:0]     r_waddr;
  logic [W-1:0]     r_wdata;
  logic [NREG-1:0]  r_pending;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [D-1:0]     w_addr;
  logic [W-1:0]     w_data;
  logic [NREG-1:0]  w_pending_nxt;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!Reset) begin
      w_gnt0 = bus.Req0_valid && (!bus.Req1_valid || r_prio == PRIO_ALU);
      w_gnt1 = bus.Req1_valid && (!bus.Req0_valid || r_prio == PRIO_LOAD);
    end
    w_addr = w_gnt1 ? bus.Req1_addr : bus.Req0_addr;
    w_data = w_gnt1 ? bus.Req1_data : bus.Req0_data;
  end

  // Clear first, then set, so a reservation on the committing edge survives.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wen) w_pending_nxt[r_waddr] = 1'b0;
    if (bus.Reserve_en && bus.Reserve_addr != '0) w_pending_nxt[bus.Reserve_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_prio    <= PRIO_ALU;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_gnt0 || w_gnt1) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
        r_wen   <= (w_addr != '0);
        r_prio  <= w_gnt0 ? PRIO_LOAD : PRIO_ALU;
      end else begin
        r_wen <= 1'b0;
      end
    end
  end

  assign bus.Req0_ready        = w_gnt0;
  assign bus.Req1_ready        = w_gnt1;
  assign bus.Read_busy_0       = !Reset && r_pending[bus.Read_addr_0];
  assign bus.Read_busy_1       = !Reset && r_pending[bus.Read_addr_1];
  assign bus.Reg_write_en      = r_wen;
  assign bus.Reg_write_address = r_waddr;
  assign bus.Reg_write_data    = r_wdata;
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed vector table, a reset-during-grant sequence,
// then randomized traffic checked against a cycle-level reference model.
module tb_reg_wb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_scheduler_if #(.W(8), .D(3)) bus ();
  reg_wb_scheduler #(.W(8), .D(3)) dut (.CLK(clk), .Reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic rst, v0; logic [2:0] a0; logic [7:0] d0;
    logic v1; logic [2:0] a1; logic [7:0] d1;
    logic ren; logic [2:0] ra, q0, q1;
    logic e_r0, e_r1, e_b0, e_b1, e_wen; logic [2:0] e_wa; logic [7:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic v0, logic [2:0] a0, logic [7:0] d0, logic v1, logic [2:0] a1, logic [7:0] d1,
    logic ren, logic [2:0] ra, logic [2:0] q0, logic [2:0] q1,
    logic e_r0, logic e_r1, logic e_b0, logic e_b1, logic e_wen, logic [2:0] e_wa, logic [7:0] e_wd);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.ren = ren; v.ra = ra; v.q0 = q0; v.q1 = q1;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_b0 = e_b0; v.e_b1 = e_b1;
    v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic ren, input logic [2:0] ra, input logic [2:0] q0, input logic [2:0] q1);
    rst = r;
    bus.Req0_valid = v0; bus.Req0_addr = a0; bus.Req0_data = d0;
    bus.Req1_valid = v1; bus.Req1_addr = a1; bus.Req1_data = d1;
    bus.Reserve_en = ren; bus.Reserve_addr = ra;
    bus.Read_addr_0 = q0; bus.Read_addr_1 = q1;
  endtask

  task automatic check_outs(input string tag, input int cyc,
                            input logic r0, input logic r1, input logic b0, input logic b1,
                            input logic wen, input logic [2:0] wa, input logic [7:0] wd);
    chk({tag, ".ready0"}, cyc, 32'(bus.Req0_ready), 32'(r0));
    chk({tag, ".ready1"}, cyc, 32'(bus.Req1_ready), 32'(r1));
    chk({tag, ".busy0"}, cyc, 32'(bus.Read_busy_0), 32'(b0));
    chk({tag, ".busy1"}, cyc, 32'(bus.Read_busy_1), 32'(b1));
    chk({tag, ".wen"}, cyc, 32'(bus.Reg_write_en), 32'(wen));
    chk({tag, ".waddr"}, cyc, 32'(bus.Reg_write_address), 32'(wa));
    chk({tag, ".wdata"}, cyc, 32'(bus.Reg_write_data), 32'(wd));
  endtask

  // Reference model state: which requester is favoured, which registers await a write,
  // and what the register file port is presenting this cycle.
  int   m_prio;
  bit   m_pend[8];
  bit   m_wen;
  int   m_waddr, m_wdata;

  task automatic model_reset();
    m_prio = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  initial begin
    logic hv0, hv1;
    logic [2:0] ha0, ha1;
    logic [7:0] hd0, hd1;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    //            rst v0 a0 d0     v1 a1 d1     ren ra q0 q1 | r0 r1 b0 b1 wen wa wd
    tbl.push_back(mk(1, 1, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 4, 8'h44, 0, 0, 0, 0,  0, 1, 0, 0, 0, 3, 8'hA5));
    tbl.push_back(mk(0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,  1, 0, 0, 0, 1, 4, 8'h44));
    tbl.push_back(mk(0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 8'h11));
    tbl.push_back(mk(0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2, 8'h22));
    tbl.push_back(mk(0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,  0, 0, 0, 0, 0, 2, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 5, 8'h55, 0, 0, 5, 0,  0, 1, 1, 0, 0, 2, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 1, 0, 1, 5, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 0, 0, 0, 5, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,  0, 0, 0, 0, 0, 5, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 5, 8'h66, 0, 0, 5, 0,  0, 1, 1, 0, 0, 5, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,  0, 0, 1, 0, 1, 5, 8'h66));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 5,  0, 0, 1, 1, 0, 5, 8'h66));
    tbl.push_back(mk(0, 1, 5, 8'h77, 0, 0, 8'h00, 0, 0, 5, 0,  1, 0, 1, 0, 0, 5, 8'h66));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 1, 0, 1, 5, 8'h77));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 0, 0, 0, 5, 8'h77));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 8'h00, 1, 0, 0, 0,  1, 0, 0, 0, 0, 5, 8'h77));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'hFF));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
            tbl[i].ren, tbl[i].ra, tbl[i].q0, tbl[i].q1);
      @(negedge clk);
      check_outs("vec", i, tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_b0, tbl[i].e_b1,
                 tbl[i].e_wen, tbl[i].e_wa, tbl[i].e_wd);
      @(posedge clk); #1;
    end

    // Reset lands on the cycle a Req1 write to a reserved register would be granted.
    drive(0, 1, 7, 8'h12, 0, 0, 8'h00, 1, 6, 0, 0);
    @(negedge clk);
    chk("rst_seq.grant0", 0, 32'(bus.Req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 8'h00, 1, 6, 8'h9A, 0, 0, 6, 0);
    @(negedge clk);
    chk("rst_seq.grant1", 1, 32'(bus.Req1_ready), 32'd1);
    chk("rst_seq.busy6", 1, 32'(bus.Read_busy_0), 32'd1);
    chk("rst_seq.wen7", 1, 32'(bus.Reg_write_en), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rst_seq.ready1_in_reset", 1, 32'(bus.Req1_ready), 32'd0);
    chk("rst_seq.busy_in_reset", 1, 32'(bus.Read_busy_0), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 6, 7);
    @(negedge clk);
    check_outs("rst_seq.after", 2, 0, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    drive(0, 1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_seq.prio0_r0", 3, 32'(bus.Req0_ready), 32'd1);
    chk("rst_seq.prio0_r1", 3, 32'(bus.Req1_ready), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    hv0 = 0; hv1 = 0; ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, ren, g0, g1;
      logic [2:0] ra, q0, q1;
      logic b0, b1;
      r = ($urandom_range(0, 99) == 0);
      // An ungranted request keeps its address and data until it wins.
      if (!hv0) begin
        hv0 = ($urandom_range(0, 9) < 6); ha0 = 3'($urandom); hd0 = 8'($urandom);
      end
      if (!hv1) begin
        hv1 = ($urandom_range(0, 9) < 6); ha1 = 3'($urandom); hd1 = 8'($urandom);
      end
      ren = ($urandom_range(0, 9) < 3);
      ra = 3'($urandom); q0 = 3'($urandom); q1 = 3'($urandom);
      drive(r, hv0, ha0, hd0, hv1, ha1, hd1, ren, ra, q0, q1);

      if (r) begin
        g0 = 0; g1 = 0;
      end else if (hv0 && hv1) begin
        g0 = (m_prio == 0); g1 = (m_prio == 1);
      end else begin
        g0 = hv0; g1 = hv1;
      end
      b0 = !r && m_pend[q0];
      b1 = !r && m_pend[q1];

      @(negedge clk);
      check_outs("rand", c, g0, g1, b0, b1, m_wen, 3'(m_waddr), 8'(m_wdata));
      @(posedge clk); #1;

      if (r) begin
        model_reset();
        hv0 = 0; hv1 = 0;
      end else begin
        if (m_wen) m_pend[m_waddr] = 0;
        if (ren && ra != 0) m_pend[ra] = 1;
        if (g0 || g1) begin
          m_waddr = g1 ? int'(ha1) : int'(ha0);
          m_wdata = g1 ? int'(hd1) : int'(hd0);
          m_wen   = (m_waddr != 0);
          m_prio  = g1 ? 0 : 1;
        end else begin
          m_wen = 0;
        end
        if (g0) hv0 = 0;
        if (g1) hv1 = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
